nios_lcd_hd44780_driver: RTL and testbench

Consumer end of the 32-bit LCD PIO output port. Decodes each command word written by the Nios II core and generates HD44780-compatible bus cycles: RS/data setup, E pulse, hold, and the execution wait. Reports completion back through status outputs that feed a PIO input port, so software polls `busy` instead of counting delays.

---
 rtl/nios_lcd_hd44780_driver.sv | 168 ++++++++++++++++
 tb/tb_nios_lcd_hd44780_driver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/nios_lcd_hd44780_driver.sv
// rtl/nios_lcd_hd44780_driver.sv - HD44780 bus-cycle generator fed by a Nios II PIO command word (option: NIOS_LCD_4BIT_EN)
module nios_lcd_hd44780_driver #(
  parameter int SETUP_CYCLES     = 4,
  parameter int EN_CYCLES        = 16,
  parameter int HOLD_CYCLES      = 4,
  parameter int EXEC_CYCLES      = 2000,
  parameter int LONG_EXEC_CYCLES = 82000,
  parameter int CNT_W            = 17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pio_word,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        busy,
  output logic        ack_tgl
);

  // Counter reload values: each phase counts down from (length-1) to zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             pending;
  logic             long_cmd;
  logic             unused_bits;

`ifdef NIOS_LCD_4BIT_EN
  logic             lo_q, lo_d;   // 0: high nibble on the bus, 1: low nibble
`endif

  // Only the data, RS and toggle fields of the PIO word carry meaning.
  assign unused_bits = ^pio_word[30:9];

  assign pending  = pio_word[31] ^ ack_q;
  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  assign long_cmd = ~rs_q & (((byte_q[7:1] == 7'b0000000) & byte_q[0]) |
                             (byte_q[7:1] == 7'b0000001));

`ifdef NIOS_LCD_4BIT_EN
  assign lcd_data = lo_q ? {byte_q[3:0], 4'b0000} : {byte_q[7:4], 4'b0000};
`else
  assign lcd_data = byte_q;
`endif
  assign lcd_rs  = rs_q;
  assign lcd_rw  = 1'b0;
  assign lcd_en  = en_q;
  assign busy    = busy_q;
  assign ack_tgl = ack_q;

  // Next-state, counter and output decode for the bus-cycle sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    en_d    = en_q;
    busy_d  = busy_q;
    ack_d   = ack_q;
`ifdef NIOS_LCD_4BIT_EN
    lo_d    = lo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pending) begin
          byte_d  = pio_word[7:0];
          rs_d    = pio_word[8];
          ack_d   = pio_word[31];
          busy_d  = 1'b1;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
`ifdef NIOS_LCD_4BIT_EN
          lo_d    = 1'b0;
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          en_d    = 1'b1;
          cnt_d   = EN_LD;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          en_d    = 1'b0;
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
`ifdef NIOS_LCD_4BIT_EN
          if (!lo_q) begin
            lo_d    = 1'b1;
            cnt_d   = SETUP_LD;
            state_d = S_SETUP;
          end else begin
            cnt_d   = long_cmd ? LONG_LD : EXEC_LD;
            state_d = S_WAIT;
          end
`else
          cnt_d   = long_cmd ? LONG_LD : EXEC_LD;
          state_d = S_WAIT;
`endif
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      byte_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
`ifdef NIOS_LCD_4BIT_EN
      lo_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
`ifdef NIOS_LCD_4BIT_EN
      lo_q    <= lo_d;
`endif
    end
  end

endmodule

// File: tb/tb_nios_lcd_hd44780_driver.sv
// tb/tb_nios_lcd_hd44780_driver.sv - directed self-checking bench for nios_lcd_hd44780_driver
module tb_nios_lcd_hd44780_driver;

  logic        clk;
  logic        reset_n;
  logic [31:0] pio_word;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic        busy;
  logic        ack_tgl;

  int n_checks = 0;
  int n_fail   = 0;

  nios_lcd_hd44780_driver #(
    .SETUP_CYCLES    (2),
    .EN_CYCLES       (3),
    .HOLD_CYCLES     (2),
    .EXEC_CYCLES     (10),
    .LONG_EXEC_CYCLES(40),
    .CNT_W           (17)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pio_word(pio_word),
    .lcd_data(lcd_data),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_en  (lcd_en),
    .busy    (busy),
    .ack_tgl (ack_tgl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Optionally drive a new word, then follow one transaction from acceptance to busy falling.
  task automatic run_txn(input string tag, input logic drive, input logic [31:0] w,
                         input logic use_a, input logic [31:0] mid_a,
                         input logic use_b, input logic [31:0] mid_b,
                         input int exp_busy, input int exp_pulses,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic exp_rs, input logic exp_ack);
    int   pulses;
    int   en_hi;
    int   first_rise;
    int   len;
    logic prev_en;
    pulses = 0; en_hi = 0; first_rise = -1; len = -1; prev_en = 1'b0;
    if (drive) begin
      @(negedge clk);
      pio_word = w;
    end
    @(negedge clk);
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_data_start"}, 32'(lcd_data), 32'(d0));
    check({tag, "_rs_start"},   32'(lcd_rs), 32'(exp_rs));
    check({tag, "_ack"},        32'(ack_tgl), 32'(exp_ack));
    check({tag, "_en_start"},   32'(lcd_en), 32'd0);
    for (int c = 1; c <= 400; c++) begin
      if (c == 3 && use_a) pio_word = mid_a;
      if (c == 6 && use_b) pio_word = mid_b;
      @(negedge clk);
      if (lcd_en && !prev_en) begin
        pulses++;
        if (pulses == 1) begin
          first_rise = c;
          check({tag, "_data_p1"}, 32'(lcd_data), 32'(d0));
        end else begin
          check({tag, "_data_p2"}, 32'(lcd_data), 32'(d1));
        end
        check({tag, "_rs_pulse"}, 32'(lcd_rs), 32'(exp_rs));
      end
      if (lcd_en) en_hi++;
      prev_en = lcd_en;
      if (!busy) begin
        len = c;
        break;
      end
    end
    check({tag, "_busy_len"},   32'(len), 32'(exp_busy));
    check({tag, "_pulses"},     32'(pulses), 32'(exp_pulses));
    check({tag, "_en_high"},    32'(en_hi), 32'(3 * exp_pulses));
    check({tag, "_first_rise"}, 32'(first_rise), 32'd2);
    check({tag, "_en_end"},     32'(lcd_en), 32'd0);
  endtask

  // Count busy/E activity over a quiet window where nothing should start.
  task automatic check_quiet(input string tag, input int n);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || lcd_en) act++;
    end
    check({tag, "_no_activity"}, 32'(act), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    pio_word = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(lcd_data), 32'h0);
    check("reset_rs",   32'(lcd_rs), 32'd0);
    check("reset_rw",   32'(lcd_rw), 32'd0);
    check("reset_en",   32'(lcd_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack",  32'(ack_tgl), 32'd0);
    reset_n = 1'b1;
    check_quiet("post_reset", 5);

`ifdef NIOS_LCD_4BIT_EN
    // 0xA5 with RS=1 as two nibbles: 2*(2+3+2)+10 = 24 busy clocks.
    run_txn("nib", 1'b1, 32'h8000_01A5, 1'b0, 32'h0, 1'b0, 32'h0,
            24, 2, 8'hA0, 8'h50, 1'b1, 1'b1);
    check("nib_idle_data", 32'(lcd_data), 32'h50);
    check_quiet("nib_after", 5);
`else
    // 'A' with RS=1: 2+3+2+10 = 17 busy clocks.
    run_txn("t1", 1'b1, 32'h8000_0141, 1'b0, 32'h0, 1'b0, 32'h0,
            17, 1, 8'h41, 8'h00, 1'b1, 1'b1);
    check("t1_rw", 32'(lcd_rw), 32'd0);
    check_quiet("t1_after", 3);
    // Clear: 2+3+2+40 = 47; a new word written mid-transaction must wait.
    run_txn("t2", 1'b1, 32'h0000_0001, 1'b1, 32'h8000_0038, 1'b0, 32'h0,
            47, 1, 8'h01, 8'h00, 1'b0, 1'b0);
    // The pending 0x38 starts after one idle clock; a 1->0->1 double toggle inside it is lost.
    run_txn("t3", 1'b0, 32'h0, 1'b1, 32'h0000_0038, 1'b1, 32'h8000_0038,
            17, 1, 8'h38, 8'h00, 1'b0, 1'b1);
    check_quiet("t4_lost", 10);
    check("t4_idle_data", 32'(lcd_data), 32'h38);
    check("t4_ack",       32'(ack_tgl), 32'd1);
`endif

    // Reset during the E pulse truncates the transaction asynchronously.
    @(negedge clk);
    pio_word = 32'h0000_0141;
    repeat (3) @(negedge clk);
    check("t5_en_before", 32'(lcd_en), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_en",   32'(lcd_en), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_data", 32'(lcd_data), 32'h0);
    check("t5_rs",   32'(lcd_rs), 32'd0);
    check("t5_ack",  32'(ack_tgl), 32'd0);
    pio_word = 32'h0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_quiet("t5_after", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
